axi_ar_latency_shim: RTL and testbench

- Sits between prefetcherTop's memory-side read port (m_ar/m_r) and axi_ram's read port.
- Delays every read address request by a programmable number of cycles, in order, to emulate DRAM latency so prefetch benefit is measurable.
- R channel passes through combinationally.
- Tracks outstanding bursts for CR-space observation.

---
 rtl/axi_ar_latency_shim_if.sv | 68 ++++++
 rtl/axi_ar_latency_shim.sv | 156 +++++++++++++++
 tb/tb_axi_ar_latency_shim.sv | 375 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_ar_latency_shim_if.sv
// +----------------------------------------------------------------------------+
// | axi_ar_latency_shim_if : AR/R bus bundle around the latency shim           |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

interface axi_ar_latency_shim_if #(
  parameter int ADDR_BITS            = 16,
  parameter int BURST_LEN_WIDTH      = 8,
  parameter int TID_WIDTH            = 8,
  parameter int LOG_BLOCK_DATA_BYTES = 0
);
  localparam int DATA_WIDTH = 8 << LOG_BLOCK_DATA_BYTES;

  // prefetcher-side AR
  logic                       s_ar_valid;
  logic                       s_ar_ready;
  logic [ADDR_BITS-1:0]       s_ar_addr;
  logic [BURST_LEN_WIDTH-1:0] s_ar_len;
  logic [TID_WIDTH-1:0]       s_ar_id;

  // RAM-side AR
  logic                       m_ar_valid;
  logic                       m_ar_ready;
  logic [ADDR_BITS-1:0]       m_ar_addr;
  logic [BURST_LEN_WIDTH-1:0] m_ar_len;
  logic [TID_WIDTH-1:0]       m_ar_id;

  // RAM-side R
  logic                       m_r_valid;
  logic                       m_r_ready;
  logic [DATA_WIDTH-1:0]      m_r_data;
  logic                       m_r_last;
  logic [TID_WIDTH-1:0]       m_r_id;

  // prefetcher-side R
  logic                       s_r_valid;
  logic                       s_r_ready;
  logic [DATA_WIDTH-1:0]      s_r_data;
  logic                       s_r_last;
  logic [TID_WIDTH-1:0]       s_r_id;

  // The shim's own view of the bundle
  modport slave (
    input  s_ar_valid, s_ar_addr, s_ar_len, s_ar_id,
    output s_ar_ready,
    output m_ar_valid, m_ar_addr, m_ar_len, m_ar_id,
    input  m_ar_ready,
    input  m_r_valid, m_r_data, m_r_last, m_r_id,
    output m_r_ready,
    output s_r_valid, s_r_data, s_r_last, s_r_id,
    input  s_r_ready
  );

  // The surrounding environment's view (prefetcher + RAM)
  modport master (
    output s_ar_valid, s_ar_addr, s_ar_len, s_ar_id,
    input  s_ar_ready,
    input  m_ar_valid, m_ar_addr, m_ar_len, m_ar_id,
    output m_ar_ready,
    output m_r_valid, m_r_data, m_r_last, m_r_id,
    input  m_r_ready,
    input  s_r_valid, s_r_data, s_r_last, s_r_id,
    output s_r_ready
  );
endinterface

`default_nettype wire

// File: rtl/axi_ar_latency_shim.sv
// +----------------------------------------------------------------------------+
// | axi_ar_latency_shim : in-order programmable AR delay queue with bypass,    |
// |                       R pass-through and outstanding-burst tracking        |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module axi_ar_latency_shim #(
  parameter int ADDR_BITS            = 16,
  parameter int BURST_LEN_WIDTH      = 8,
  parameter int TID_WIDTH            = 8,
  parameter int LOG_BLOCK_DATA_BYTES = 0,
  parameter int LOG_DEPTH            = 2,
  parameter int LAT_WIDTH            = 8,
  parameter int OUT_CNT_WIDTH        = 8
) (
  input  wire logic                     clk,
  input  wire logic                     rst,
  input  wire logic                     en,
  input  wire logic [LAT_WIDTH-1:0]     crs_latency,
  axi_ar_latency_shim_if.slave          bus,
  output logic [LOG_DEPTH:0]            queueCnt,
  output logic [OUT_CNT_WIDTH-1:0]      outstandingCnt,
  output logic                          overflowErr
);

  localparam int                 DEPTH    = 1 << LOG_DEPTH;
  localparam logic [LOG_DEPTH:0] FULL_CNT = (LOG_DEPTH + 1)'(DEPTH);

  logic [ADDR_BITS-1:0]       r_addr [DEPTH];
  logic [BURST_LEN_WIDTH-1:0] r_len  [DEPTH];
  logic [TID_WIDTH-1:0]       r_id   [DEPTH];
  logic [LAT_WIDTH-1:0]       r_cnt  [DEPTH];
  logic [DEPTH-1:0]           r_vld;
  logic [DEPTH-1:0]           r_ripe;
  logic [LOG_DEPTH-1:0]       r_head;
  logic [LOG_DEPTH-1:0]       r_tail;
  logic [LOG_DEPTH:0]         r_qcnt;
  logic                       r_en_mode;
  logic [OUT_CNT_WIDTH-1:0]   r_out;
  logic                       r_ovf;

  logic                       w_full;
  logic                       w_bypass;
  logic                       w_head_rdy;
  logic                       w_s_ar_ready;
  logic                       w_m_ar_valid;
  logic                       w_push;
  logic                       w_pop;
  logic                       w_issue;
  logic                       w_r_done;

  assign w_full     = (r_qcnt == FULL_CNT);
  assign w_bypass   = ~r_en_mode & (r_qcnt == '0);
  // An entry becomes issuable one edge after its countdown has reached zero,
  // which gives the registered k+latency+1 issue point.
  assign w_head_rdy = r_vld[r_head] & r_ripe[r_head];

  always_comb begin
    w_s_ar_ready = 1'b0;
    w_m_ar_valid = 1'b0;
    if (!rst) begin
      if (w_bypass) begin
        w_s_ar_ready = bus.m_ar_ready;
        w_m_ar_valid = bus.s_ar_valid;
      end else begin
        w_s_ar_ready = r_en_mode & ~w_full;
        w_m_ar_valid = w_head_rdy;
      end
    end
  end

  assign bus.s_ar_ready = w_s_ar_ready;
  assign bus.m_ar_valid = w_m_ar_valid;
  assign bus.m_ar_addr  = w_bypass ? bus.s_ar_addr : r_addr[r_head];
  assign bus.m_ar_len   = w_bypass ? bus.s_ar_len  : r_len[r_head];
  assign bus.m_ar_id    = w_bypass ? bus.s_ar_id   : r_id[r_head];

  assign w_push   = ~w_bypass & bus.s_ar_valid & w_s_ar_ready;
  assign w_pop    = ~w_bypass & w_m_ar_valid & bus.m_ar_ready;
  assign w_issue  = w_m_ar_valid & bus.m_ar_ready;
  assign w_r_done = bus.m_r_valid & bus.s_r_ready & bus.m_r_last;

  // R channel is a pure wire-through in both modes.
  assign bus.s_r_valid = bus.m_r_valid;
  assign bus.s_r_data  = bus.m_r_data;
  assign bus.s_r_last  = bus.m_r_last;
  assign bus.s_r_id    = bus.m_r_id;
  assign bus.m_r_ready = bus.s_r_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head    <= '0;
      r_tail    <= '0;
      r_qcnt    <= '0;
      r_vld     <= '0;
      r_ripe    <= '0;
      r_en_mode <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_en_mode <= en;
      for (int i = 0; i < DEPTH; i++) begin
        if (r_vld[i]) begin
          if (r_cnt[i] == '0) begin
            r_ripe[i] <= 1'b1;
          end else begin
            r_cnt[i] <= r_cnt[i] - 1'b1;
          end
        end
      end
      if (w_pop) begin
        r_vld[r_head]  <= 1'b0;
        r_ripe[r_head] <= 1'b0;
        r_head         <= r_head + 1'b1;
      end
      if (w_push) begin
        r_vld[r_tail]  <= 1'b1;
        r_ripe[r_tail] <= 1'b0;
        r_cnt[r_tail]  <= crs_latency;
        r_addr[r_tail] <= bus.s_ar_addr;
        r_len[r_tail]  <= bus.s_ar_len;
        r_id[r_tail]   <= bus.s_ar_id;
        r_tail         <= r_tail + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_qcnt <= r_qcnt + 1'b1;
      end else if (w_pop && !w_push) begin
        r_qcnt <= r_qcnt - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out <= '0;
      r_ovf <= 1'b0;
    end else if (w_issue && !w_r_done) begin
      if (&r_out) begin
        r_ovf <= 1'b1;
      end else begin
        r_out <= r_out + 1'b1;
      end
    end else if (w_r_done && !w_issue && (r_out != '0)) begin
      r_out <= r_out - 1'b1;
    end
  end

  assign queueCnt       = r_qcnt;
  assign outstandingCnt = r_out;
  assign overflowErr    = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_axi_ar_latency_shim.sv
// +----------------------------------------------------------------------------+
// | tb_axi_ar_latency_shim : self-checking bench for axi_ar_latency_shim       |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_axi_ar_latency_shim;
  localparam int AW    = 16;
  localparam int LW    = 8;
  localparam int IW    = 8;
  localparam int LB    = 0;
  localparam int LD    = 2;
  localparam int TW    = 8;
  localparam int OW    = 8;
  localparam int DW    = 8 << LB;
  localparam int DEPTH = 1 << LD;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en  = 1'b0;
  logic [TW-1:0] lat = '0;
  logic [LD:0]   qcnt;
  logic [OW-1:0] ocnt;
  logic          ovf;

  axi_ar_latency_shim_if #(.ADDR_BITS(AW), .BURST_LEN_WIDTH(LW), .TID_WIDTH(IW),
                           .LOG_BLOCK_DATA_BYTES(LB)) bus ();

  axi_ar_latency_shim #(
    .ADDR_BITS(AW), .BURST_LEN_WIDTH(LW), .TID_WIDTH(IW), .LOG_BLOCK_DATA_BYTES(LB),
    .LOG_DEPTH(LD), .LAT_WIDTH(TW), .OUT_CNT_WIDTH(OW)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .crs_latency(lat), .bus(bus),
    .queueCnt(qcnt), .outstandingCnt(ocnt), .overflowErr(ovf)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Record every m_ar handshake with the edge index preceding it
  logic [AW-1:0] iss_addr[$];
  int            iss_cyc[$];
  always @(negedge clk) begin
    if (bus.m_ar_valid === 1'b1 && bus.m_ar_ready === 1'b1) begin
      iss_addr.push_back(bus.m_ar_addr);
      iss_cyc.push_back(cyc);
    end
  end

  // Behavioural reference: an AR seen accepted before edge t+1 becomes
  // issuable from cycle t+1+L+1; issue is strictly in arrival order.
  typedef struct {
    logic [AW-1:0] addr;
    logic [LW-1:0] len;
    logic [IW-1:0] id;
    int            rdy;
  } ar_t;
  ar_t     mq[$];
  int      m_out;
  bit      model_on = 0;

  always @(negedge clk) begin
    if (model_on) begin
      bit e_sready, e_mvalid, rdone;
      e_sready = (mq.size() < DEPTH);
      e_mvalid = (mq.size() > 0) && (mq[0].rdy <= cyc);
      check("rnd_s_ar_ready", bus.s_ar_ready, e_sready);
      check("rnd_m_ar_valid", bus.m_ar_valid, e_mvalid);
      if (e_mvalid) begin
        check("rnd_m_ar_addr", bus.m_ar_addr, mq[0].addr);
        check("rnd_m_ar_len",  bus.m_ar_len,  mq[0].len);
        check("rnd_m_ar_id",   bus.m_ar_id,   mq[0].id);
      end
      check("rnd_queueCnt", qcnt, mq.size());
      check("rnd_outstanding", ocnt, m_out);
      check("rnd_s_r_valid", bus.s_r_valid, bus.m_r_valid);
      check("rnd_s_r_data", bus.s_r_data, bus.m_r_data);
      check("rnd_m_r_ready", bus.m_r_ready, bus.s_r_ready);
      rdone = bus.m_r_valid && bus.s_r_ready && bus.m_r_last;
      if (e_mvalid && bus.m_ar_ready) void'(mq.pop_front());
      if (bus.s_ar_valid && e_sready)
        mq.push_back('{bus.s_ar_addr, bus.s_ar_len, bus.s_ar_id, cyc + int'(lat) + 2});
      if (e_mvalid && bus.m_ar_ready && !rdone) m_out = (m_out == 255) ? 255 : m_out + 1;
      else if (rdone && !(e_mvalid && bus.m_ar_ready)) m_out = (m_out == 0) ? 0 : m_out - 1;
    end
  end

  task automatic idle_inputs();
    bus.s_ar_valid = 0; bus.s_ar_addr = '0; bus.s_ar_len = '0; bus.s_ar_id = '0;
    bus.m_ar_ready = 0;
    bus.m_r_valid = 0; bus.m_r_data = '0; bus.m_r_last = 0; bus.m_r_id = '0;
    bus.s_r_ready = 0;
  endtask

  task automatic do_reset(input logic en_val);
    idle_inputs();
    rst = 1; en = en_val;
    tick(); tick();
    rst = 0;
    tick(); tick();
    iss_addr.delete(); iss_cyc.delete();
  endtask

  task automatic push_ar(input logic [AW-1:0] a, input logic [IW-1:0] i, output int k);
    bus.s_ar_valid = 1; bus.s_ar_addr = a; bus.s_ar_id = i; bus.s_ar_len = '0;
    @(negedge clk);
    check("push_ready", bus.s_ar_ready, 1'b1);
    tick();
    k = cyc;
    bus.s_ar_valid = 0;
  endtask

  typedef struct {
    logic          sv;
    logic          mr;
    logic [AW-1:0] addr;
    logic          rv;
    logic          rl;
    logic          rr;
    logic [DW-1:0] rd;
    logic          e_mv;
    logic          e_sr;
    logic [OW-1:0] e_out;
  } vec_t;
  vec_t tbl[10];

  initial begin
    int k, ka, kb, n;
    tbl[0] = '{1, 1, 16'h0100, 0, 0, 0, 8'h11, 1, 1, 8'd1};
    tbl[1] = '{1, 0, 16'h0101, 0, 0, 0, 8'h22, 1, 0, 8'd1};
    tbl[2] = '{0, 1, 16'h0102, 1, 1, 1, 8'h33, 0, 1, 8'd0};
    tbl[3] = '{1, 1, 16'h0103, 1, 1, 1, 8'h44, 1, 1, 8'd0};
    tbl[4] = '{0, 0, 16'h0104, 1, 1, 1, 8'h55, 0, 0, 8'd0};
    tbl[5] = '{1, 1, 16'h0105, 0, 0, 0, 8'h66, 1, 1, 8'd1};
    tbl[6] = '{0, 1, 16'h0106, 1, 0, 1, 8'h77, 0, 1, 8'd1};
    tbl[7] = '{0, 0, 16'h0107, 1, 1, 0, 8'h88, 0, 0, 8'd1};
    tbl[8] = '{1, 1, 16'h0108, 1, 1, 1, 8'h99, 1, 1, 8'd1};
    tbl[9] = '{0, 1, 16'h0109, 1, 1, 1, 8'hAA, 0, 1, 8'd0};

    // Reset cycle: outputs gated even with both sides requesting
    idle_inputs();
    bus.s_ar_valid = 1; bus.m_ar_ready = 1;
    @(negedge clk);
    check("rst_m_ar_valid", bus.m_ar_valid, 1'b0);
    check("rst_s_ar_ready", bus.s_ar_ready, 1'b0);
    tick();
    check("rst_queueCnt", qcnt, 0);
    check("rst_outstanding", ocnt, 0);
    check("rst_overflow", ovf, 1'b0);

    // Bypass table
    do_reset(1'b0);
    for (int i = 0; i < 10; i++) begin
      bus.s_ar_valid = tbl[i].sv; bus.m_ar_ready = tbl[i].mr; bus.s_ar_addr = tbl[i].addr;
      bus.m_r_valid = tbl[i].rv; bus.m_r_last = tbl[i].rl; bus.s_r_ready = tbl[i].rr;
      bus.m_r_data = tbl[i].rd; bus.m_r_id = IW'(i);
      @(negedge clk);
      check("tbl_m_ar_valid", bus.m_ar_valid, tbl[i].e_mv);
      check("tbl_s_ar_ready", bus.s_ar_ready, tbl[i].e_sr);
      if (tbl[i].sv) check("tbl_m_ar_addr", bus.m_ar_addr, tbl[i].addr);
      check("tbl_s_r_valid", bus.s_r_valid, tbl[i].rv);
      check("tbl_s_r_last", bus.s_r_last, tbl[i].rl);
      check("tbl_s_r_data", bus.s_r_data, tbl[i].rd);
      check("tbl_s_r_id", bus.s_r_id, i);
      check("tbl_m_r_ready", bus.m_r_ready, tbl[i].rr);
      tick();
      check("tbl_outstanding", ocnt, tbl[i].e_out);
    end

    // Outstanding saturation
    do_reset(1'b0);
    bus.s_ar_valid = 1; bus.m_ar_ready = 1;
    for (int i = 0; i < 255; i++) tick();
    check("sat_cnt_255", ocnt, 255);
    check("sat_ovf_clear", ovf, 1'b0);
    tick();
    check("sat_cnt_hold", ocnt, 255);
    check("sat_ovf_set", ovf, 1'b1);
    bus.s_ar_valid = 0; bus.m_r_valid = 1; bus.m_r_last = 1; bus.s_r_ready = 1;
    tick();
    check("sat_dec", ocnt, 254);
    check("sat_ovf_sticky", ovf, 1'b1);

    // 1: single AR, latency 5
    do_reset(1'b1);
    lat = 5; bus.m_ar_ready = 1;
    push_ar(16'h0EEF, 8'd5, k);
    check("t1_queueCnt", qcnt, 1);
    for (int j = 0; j <= 6; j++) begin
      @(negedge clk);
      check("t1_m_ar_valid", bus.m_ar_valid, (j == 6));
      if (j == 6) begin
        check("t1_addr", bus.m_ar_addr, 16'h0EEF);
        check("t1_id", bus.m_ar_id, 5);
      end
      tick();
    end
    @(negedge clk);
    check("t1_outstanding_1", ocnt, 1);
    check("t1_one_issue", iss_addr.size(), 1);
    check("t1_valid_drop", bus.m_ar_valid, 1'b0);
    tick();
    bus.m_r_valid = 1; bus.m_r_last = 1; bus.m_r_id = 5; bus.m_r_data = 8'h5A; bus.s_r_ready = 1;
    @(negedge clk);
    check("t1_s_r_id", bus.s_r_id, 5);
    tick();
    bus.m_r_valid = 0;
    check("t1_outstanding_0", ocnt, 0);

    // 2+3: fill with ready low, then pop attempt while full
    do_reset(1'b1);
    lat = 0;
    bus.s_ar_valid = 1;
    for (int i = 0; i < 4; i++) begin
      bus.s_ar_addr = AW'(16'h0EEF + i);
      @(negedge clk);
      check("t2_fill_ready", bus.s_ar_ready, 1'b1);
      tick();
    end
    bus.s_ar_addr = 16'h0EF3;
    @(negedge clk);
    check("t2_full_cnt", qcnt, 4);
    check("t2_full_ready", bus.s_ar_ready, 1'b0);
    check("t2_head_addr", bus.m_ar_addr, 16'h0EEF);
    tick();
    @(negedge clk);
    check("t2_hold_valid", bus.m_ar_valid, 1'b1);
    check("t2_hold_addr", bus.m_ar_addr, 16'h0EEF);
    tick();
    bus.m_ar_ready = 1;
    @(negedge clk);
    check("t3_full_pop_ready", bus.s_ar_ready, 1'b0);
    tick();
    @(negedge clk);
    check("t3_after_pop_cnt", qcnt, 3);
    check("t3_after_pop_ready", bus.s_ar_ready, 1'b1);
    tick();
    bus.s_ar_valid = 0;
    @(negedge clk);
    check("t3_push_pop_cnt", qcnt, 3);
    for (int i = 0; i < 6; i++) tick();
    check("t2_drained", qcnt, 0);
    check("t2_issue_count", iss_addr.size(), 5);
    if (iss_addr.size() == 5) begin
      for (int i = 0; i < 5; i++) begin
        check("t2_issue_order", iss_addr[i], AW'(16'h0EEF + i));
        if (i > 0) check("t2_issue_spacing", iss_cyc[i] - iss_cyc[i-1], 1);
      end
    end

    // 4: head-of-line blocking after latency change
    do_reset(1'b1);
    lat = 10; bus.m_ar_ready = 1;
    push_ar(16'h1000, 8'd1, ka);
    lat = 0;
    push_ar(16'h2000, 8'd2, kb);
    tick(); tick(); tick();
    @(negedge clk);
    check("t4_hol_blocked", bus.m_ar_valid, 1'b0);
    check("t4_hol_cnt", qcnt, 2);
    n = 0;
    while (iss_addr.size() < 2 && n < 40) begin tick(); n++; end
    check("t4_issue_count", iss_addr.size(), 2);
    if (iss_addr.size() == 2) begin
      check("t4_first", iss_addr[0], 16'h1000);
      check("t4_second", iss_addr[1], 16'h2000);
      check("t4_first_lat", iss_cyc[0] - ka, 11);
      check("t4_second_after", iss_cyc[1] - iss_cyc[0], 1);
    end

    // 5: drop en with entries pending, then combinational bypass
    do_reset(1'b1);
    lat = 3; bus.m_ar_ready = 1;
    push_ar(16'h3000, 8'd3, k);
    push_ar(16'h3001, 8'd4, k);
    en = 0;
    tick();
    bus.s_ar_valid = 1; bus.s_ar_addr = 16'h0100; bus.s_ar_id = 8'd9;
    n = 0;
    @(negedge clk);
    while (qcnt != 0 && n < 20) begin
      check("t5_blocked_ready", bus.s_ar_ready, 1'b0);
      tick(); n++;
      @(negedge clk);
    end
    check("t5_drained", qcnt, 0);
    check("t5_bypass_valid", bus.m_ar_valid, 1'b1);
    check("t5_bypass_addr", bus.m_ar_addr, 16'h0100);
    check("t5_bypass_ready", bus.s_ar_ready, 1'b1);
    tick();
    bus.m_ar_ready = 0;
    #1;
    check("t5_bypass_ready_follow", bus.s_ar_ready, 1'b0);
    bus.s_ar_valid = 0;
    tick();
    check("t5_issue_count", iss_addr.size(), 3);
    if (iss_addr.size() == 3) begin
      check("t5_order0", iss_addr[0], 16'h3000);
      check("t5_order1", iss_addr[1], 16'h3001);
      check("t5_order2", iss_addr[2], 16'h0100);
    end

    // 6: reset with three pending entries
    en = 1; tick(); tick();
    lat = 20; bus.m_ar_ready = 1;
    push_ar(16'h4000, 8'd1, k);
    push_ar(16'h4001, 8'd1, k);
    push_ar(16'h4002, 8'd1, k);
    @(negedge clk);
    check("t6_pending", qcnt, 3);
    check("t6_out_before", ocnt, 3);
    iss_addr.delete(); iss_cyc.delete();
    tick();
    rst = 1;
    tick();
    rst = 0;
    @(negedge clk);
    check("t6_cnt_cleared", qcnt, 0);
    check("t6_valid_low", bus.m_ar_valid, 1'b0);
    check("t6_out_cleared", ocnt, 0);
    for (int i = 0; i < 30; i++) tick();
    check("t6_never_issued", iss_addr.size(), 0);

    // Randomised run against the reference model
    do_reset(1'b1);
    mq.delete(); m_out = 0;
    for (int i = 0; i < 800; i++) begin
      bus.s_ar_valid = 1'($urandom_range(0, 1));
      bus.s_ar_addr  = AW'($urandom);
      bus.s_ar_len   = LW'($urandom);
      bus.s_ar_id    = IW'($urandom);
      lat            = TW'($urandom_range(0, 6));
      bus.m_ar_ready = ($urandom_range(0, 3) != 0);
      bus.m_r_valid  = 1'($urandom_range(0, 1));
      bus.m_r_last   = 1'($urandom_range(0, 1));
      bus.m_r_data   = DW'($urandom);
      bus.m_r_id     = IW'($urandom);
      bus.s_r_ready  = 1'($urandom_range(0, 1));
      model_on = 1;
      tick();
    end
    model_on = 0;
    idle_inputs();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
